// File: rtl/fir_decimator.sv
// fir_decimator: keeps one of every DECIM accepted samples and queues it in a small output FIFO.
// Define FIR_DECIM_DROP_CNT_EN to add a saturating dropped-sample counter port (drop_cnt).
module fir_decimator #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned DECIM      = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1,
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_p,
   input  logic                     en,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] y_in,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PW-1:0]            phase,
   output logic [LW-1:0]            fifo_level,
   output logic                     overflow,
   input  logic                     clr_ovf
`ifdef FIR_DECIM_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);

   localparam int unsigned     AW       = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0]   PH_LAST  = PW'(DECIM - 1);
   localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH);

   logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]            rd_ptr;
   logic [AW-1:0]            wr_ptr;
   logic [LW-1:0]            count;
   logic signed [DATA_W-1:0] hold_q;
   logic                     acc;
   logic                     keep;
   logic                     full;
   logic                     pop;
   logic                     push;
   logic                     drop;

   // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
   always_comb begin
      acc  = en & in_valid;
      keep = acc & (phase == '0);
      full = (count == FULL_LVL);
      pop  = out_valid & out_ready;
      push = keep & (~full | pop);
      drop = keep & full & ~pop;
   end

   assign out_valid  = (count != '0);
   assign out_data   = out_valid ? mem[rd_ptr] : hold_q;
   assign fifo_level = count;

   always_ff @(posedge clk) begin
      if (rst_p) begin
         phase    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         hold_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (acc) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         // Remember the departing head so out_data holds it once the FIFO drains.
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst_p) begin
         mem[wr_ptr] <= y_in;
      end
   end

`ifdef FIR_DECIM_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst_p) begin
         drop_cnt <= '0;
      end else if (clr_ovf) begin
         drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: directed scenarios plus a randomized run against a queue-based model.
// Two instances share stimulus: dut_a (DECIM=4) and dut_b (DECIM=1).
module tb_fir_decimator;

   localparam int DECIM_A = 4;
   localparam int DEPTH   = 4;

   logic clk = 1'b0;
   logic rst_p = 1'b0;
   logic en = 1'b0;
   logic in_valid = 1'b0;
   logic [15:0] y_in = '0;
   logic out_ready = 1'b0;
   logic clr_ovf = 1'b0;

   logic [15:0] oa_data, ob_data;
   logic        oa_valid, ob_valid;
   logic [1:0]  pa;
   logic [0:0]  pb;
   logic [2:0]  la, lb;
   logic        ova, ovb;
`ifdef FIR_DECIM_DROP_CNT_EN
   logic [15:0] dca, dcb;
`endif

   int total = 0;
   int bad = 0;

   // Reference model state: one queue per instance.
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   int          m_phase[2];
   logic [15:0] m_last[2];
   bit          m_ovf[2];
   int          m_dc[2];

   always #5 clk = ~clk;

   fir_decimator #(.DATA_W(16), .DECIM(DECIM_A), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst_p(rst_p), .en(en), .in_valid(in_valid), .y_in(y_in),
      .out_data(oa_data), .out_valid(oa_valid), .out_ready(out_ready),
      .phase(pa), .fifo_level(la), .overflow(ova), .clr_ovf(clr_ovf)
`ifdef FIR_DECIM_DROP_CNT_EN
      , .drop_cnt(dca)
`endif
   );

   fir_decimator #(.DATA_W(16), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst_p(rst_p), .en(en), .in_valid(in_valid), .y_in(y_in),
      .out_data(ob_data), .out_valid(ob_valid), .out_ready(out_ready),
      .phase(pb), .fifo_level(lb), .overflow(ovb), .clr_ovf(clr_ovf)
`ifdef FIR_DECIM_DROP_CNT_EN
      , .drop_cnt(dcb)
`endif
   );

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int n;
         bit keep, pop, drop;
         n    = (k == 0) ? qa.size() : qb.size();
         keep = en && in_valid && (m_phase[k] == 0);
         pop  = (n != 0) && out_ready;
         drop = 1'b0;
         if (rst_p) begin
            if (k == 0) qa.delete(); else qb.delete();
            m_phase[k] = 0;
            m_last[k]  = '0;
            m_ovf[k]   = 1'b0;
            m_dc[k]    = 0;
         end else begin
            if (pop) begin
               if (k == 0) m_last[k] = qa.pop_front();
               else        m_last[k] = qb.pop_front();
               n--;
            end
            if (keep) begin
               if (n < DEPTH) begin
                  if (k == 0) qa.push_back(y_in); else qb.push_back(y_in);
               end else begin
                  drop = 1'b1;
               end
            end
            if (en && in_valid) m_phase[k] = (m_phase[k] + 1) % ((k == 0) ? DECIM_A : 1);
            if (drop) m_ovf[k] = 1'b1;
            else if (clr_ovf) m_ovf[k] = 1'b0;
            if (clr_ovf) m_dc[k] = drop ? 1 : 0;
            else if (drop && m_dc[k] < 65535) m_dc[k]++;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_p = 1'b1;
      tick();
      rst_p = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (oa_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%0b exp=0", oa_valid); end
      total++; if (oa_data !== 16'h0) begin bad++; $display("FAIL reset_data_a got=%h exp=0000", oa_data); end
      total++; if (pa !== 2'd0) begin bad++; $display("FAIL reset_phase_a got=%0d exp=0", pa); end
      total++; if (la !== 3'd0) begin bad++; $display("FAIL reset_level_a got=%0d exp=0", la); end
      total++; if (ova !== 1'b0) begin bad++; $display("FAIL reset_ovf_a got=%0b exp=0", ova); end
      total++; if (ob_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%0b exp=0", ob_valid); end
      total++; if (lb !== 3'd0) begin bad++; $display("FAIL reset_level_b got=%0d exp=0", lb); end
   endtask

   task automatic test_basic();
      en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         y_in = 16'(i);
         total++;
         if (pa !== 2'((i - 1) % 4)) begin
            bad++; $display("FAIL basic_phase i=%0d got=%0d exp=%0d", i, pa, (i - 1) % 4);
         end
         tick();
         total++;
         if (oa_valid !== ((i - 1) % 4 == 0)) begin
            bad++; $display("FAIL basic_valid i=%0d got=%0b exp=%0b", i, oa_valid, (i - 1) % 4 == 0);
         end
         if ((i - 1) % 4 == 0) begin
            total++;
            if (oa_data !== 16'(i)) begin bad++; $display("FAIL basic_data got=%0d exp=%0d", oa_data, i); end
         end
      end
   endtask

   task automatic test_signed_gating();
      en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      y_in = 16'h8000;
      tick();
      total++; if (oa_valid !== 1'b1) begin bad++; $display("FAIL signed_valid got=%0b exp=1", oa_valid); end
      total++; if (oa_data !== 16'h8000) begin bad++; $display("FAIL signed_data got=%h exp=8000", oa_data); end
      total++; if (pa !== 2'd1) begin bad++; $display("FAIL signed_phase got=%0d exp=1", pa); end
      en = 1'b0; y_in = 16'd7;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (pa !== 2'd1) begin bad++; $display("FAIL gate_phase got=%0d exp=1", pa); end
         total++; if (la !== 3'd0) begin bad++; $display("FAIL gate_level got=%0d exp=0", la); end
         total++; if (oa_data !== 16'h8000) begin bad++; $display("FAIL gate_hold got=%h exp=8000", oa_data); end
      end
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (oa_valid !== 1'b0) begin bad++; $display("FAIL gate_discard got=%0b exp=0", oa_valid); end
      end
      total++; if (pa !== 2'd0) begin bad++; $display("FAIL gate_realign got=%0d exp=0", pa); end
   endtask

   task automatic test_overflow();
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         y_in = 16'(10 + i);
         tick();
         total++;
         if (lb !== 3'((i + 1 > 4) ? 4 : i + 1)) begin bad++; $display("FAIL ovf_level i=%0d got=%0d", i, lb); end
         total++;
         if (ovb !== (i == 4)) begin bad++; $display("FAIL ovf_flag i=%0d got=%0b exp=%0b", i, ovb, i == 4); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         total++; if (ob_valid !== 1'b1) begin bad++; $display("FAIL drain_valid j=%0d got=%0b exp=1", j, ob_valid); end
         total++; if (ob_data !== 16'(10 + j)) begin bad++; $display("FAIL drain_data got=%0d exp=%0d", ob_data, 10 + j); end
         tick();
      end
      total++; if (ob_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b exp=0", ob_valid); end
      total++; if (ovb !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovb); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      total++; if (ovb !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", ovb); end
   endtask

   task automatic test_full_pushpop();
      en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         y_in = 16'(20 + i);
         tick();
      end
      total++; if (lb !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", lb); end
      out_ready = 1'b1; y_in = 16'd24;
      tick();
      total++; if (lb !== 3'd4) begin bad++; $display("FAIL pushpop_level got=%0d exp=4", lb); end
      total++; if (ovb !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%0b exp=0", ovb); end
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         total++; if (ob_data !== 16'(21 + j)) begin bad++; $display("FAIL pushpop_order got=%0d exp=%0d", ob_data, 21 + j); end
         tick();
      end
      total++; if (ob_valid !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%0b exp=0", ob_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         y_in = 16'(100 + i);
         tick();
      end
      total++; if (la !== 3'd3) begin bad++; $display("FAIL mid_level got=%0d exp=3", la); end
      total++; if (pa !== 2'd2) begin bad++; $display("FAIL mid_phase got=%0d exp=2", pa); end
      total++; if (oa_data !== 16'd100) begin bad++; $display("FAIL mid_head got=%0d exp=100", oa_data); end
      rst_p = 1'b1;
      tick();
      rst_p = 1'b0;
      total++; if (oa_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b exp=0", oa_valid); end
      total++; if (oa_data !== 16'd0) begin bad++; $display("FAIL mid_rst_data got=%0d exp=0", oa_data); end
      total++; if (pa !== 2'd0) begin bad++; $display("FAIL mid_rst_phase got=%0d exp=0", pa); end
      total++; if (la !== 3'd0) begin bad++; $display("FAIL mid_rst_level got=%0d exp=0", la); end
      out_ready = 1'b1; y_in = 16'd77;
      tick();
      total++; if (oa_valid !== 1'b1) begin bad++; $display("FAIL mid_first_valid got=%0b exp=1", oa_valid); end
      total++; if (oa_data !== 16'd77) begin bad++; $display("FAIL mid_first_data got=%0d exp=77", oa_data); end
      total++; if (pa !== 2'd1) begin bad++; $display("FAIL mid_first_phase got=%0d exp=1", pa); end
   endtask

`ifdef FIR_DECIM_DROP_CNT_EN
   task automatic test_drop_cnt();
      do_reset();
      en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         y_in = 16'(200 + i);
         tick();
      end
      total++; if (dcb !== 16'd6) begin bad++; $display("FAIL dcnt_six got=%0d exp=6", dcb); end
      total++; if (ovb !== 1'b1) begin bad++; $display("FAIL dcnt_ovf got=%0b exp=1", ovb); end
      total++; if (dca !== 16'd0) begin bad++; $display("FAIL dcnt_a got=%0d exp=0", dca); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      total++; if (dcb !== 16'd1) begin bad++; $display("FAIL dcnt_clr_drop got=%0d exp=1", dcb); end
      total++; if (ovb !== 1'b1) begin bad++; $display("FAIL dcnt_set_wins got=%0b exp=1", ovb); end
   endtask
`endif

   task automatic test_random();
      logic [15:0] ea, eb;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         en        = ($urandom_range(0, 9) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_ovf   = ($urandom_range(0, 49) == 0);
         rst_p     = ($urandom_range(0, 499) == 0);
         y_in      = 16'($urandom);
         tick();
         ea = (qa.size() != 0) ? qa[0] : m_last[0];
         eb = (qb.size() != 0) ? qb[0] : m_last[1];
         total++; if (oa_valid !== (qa.size() != 0)) begin bad++; $display("FAIL rnd_valid_a c=%0d got=%0b", c, oa_valid); end
         total++; if (oa_data !== ea) begin bad++; $display("FAIL rnd_data_a c=%0d got=%h exp=%h", c, oa_data, ea); end
         total++; if (pa !== 2'(m_phase[0])) begin bad++; $display("FAIL rnd_phase_a c=%0d got=%0d exp=%0d", c, pa, m_phase[0]); end
         total++; if (la !== 3'(qa.size())) begin bad++; $display("FAIL rnd_level_a c=%0d got=%0d exp=%0d", c, la, qa.size()); end
         total++; if (ova !== m_ovf[0]) begin bad++; $display("FAIL rnd_ovf_a c=%0d got=%0b exp=%0b", c, ova, m_ovf[0]); end
         total++; if (ob_valid !== (qb.size() != 0)) begin bad++; $display("FAIL rnd_valid_b c=%0d got=%0b", c, ob_valid); end
         total++; if (ob_data !== eb) begin bad++; $display("FAIL rnd_data_b c=%0d got=%h exp=%h", c, ob_data, eb); end
         total++; if (pb !== 1'(m_phase[1])) begin bad++; $display("FAIL rnd_phase_b c=%0d got=%0d exp=%0d", c, pb, m_phase[1]); end
         total++; if (lb !== 3'(qb.size())) begin bad++; $display("FAIL rnd_level_b c=%0d got=%0d exp=%0d", c, lb, qb.size()); end
         total++; if (ovb !== m_ovf[1]) begin bad++; $display("FAIL rnd_ovf_b c=%0d got=%0b exp=%0b", c, ovb, m_ovf[1]); end
`ifdef FIR_DECIM_DROP_CNT_EN
         total++; if (dca !== 16'(m_dc[0])) begin bad++; $display("FAIL rnd_dcnt_a c=%0d got=%0d exp=%0d", c, dca, m_dc[0]); end
         total++; if (dcb !== 16'(m_dc[1])) begin bad++; $display("FAIL rnd_dcnt_b c=%0d got=%0d exp=%0d", c, dcb, m_dc[1]); end
`endif
      end
      rst_p = 1'b0;
      clr_ovf = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_signed_gating();
      test_overflow();
      test_full_pushpop();
      test_reset_mid();
`ifdef FIR_DECIM_DROP_CNT_EN
      test_drop_cnt();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
